// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, FSM state encoding and iterative-op helper for alu2
package alu_pkg;
    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_ADC = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_SBB = 6'd3;
    localparam logic [5:0] OP_INC = 6'd4;
    localparam logic [5:0] OP_DEC = 6'd5;
    localparam logic [5:0] OP_AND = 6'd6;
    localparam logic [5:0] OP_OR  = 6'd7;
    localparam logic [5:0] OP_XOR = 6'd8;
    localparam logic [5:0] OP_SHL = 6'd9;
    localparam logic [5:0] OP_SHR = 6'd10;
    localparam logic [5:0] OP_ROL = 6'd11;
    localparam logic [5:0] OP_ROR = 6'd12;
    localparam logic [5:0] OP_MUL = 6'd13;
    localparam logic [5:0] OP_DIV = 6'd14;
    localparam logic [5:0] OP_CMP = 6'd15;
    localparam logic [5:0] OP_SHA = 6'd16;
    localparam logic [5:0] OP_STC = 6'd17;
    localparam logic [5:0] OP_CLC = 6'd18;
    localparam logic [5:0] OP_MUH = 6'd19;
    localparam logic [5:0] OP_MOD = 6'd20;
    localparam logic [5:0] OP_BAD = 6'd63;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

    function automatic logic is_iterative(input logic [5:0] op);
        return op inside {OP_MUL, OP_MUH, OP_DIV, OP_MOD};
    endfunction
endpackage

// File: rtl/alu2_adder.sv
// adder: WIDTH-bit adder with carry-in, carry-out and signed overflow
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             vo
);
    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign vo = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/alu2.sv
// alu2: multi-cycle ALU with single-cycle ops and an iterative mul/div datapath
module alu2 import alu_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int OPW   = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] ai,
    input  logic [WIDTH-1:0] bi,
    input  logic [WIDTH-1:0] di,
    input  logic             ci,
    input  logic             vi,
    input  logic             zi,
    input  logic             si,
    output logic [WIDTH-1:0] res,
    output logic             co,
    output logic             vo,
    output logic             zo,
    output logic             so,
    output logic             busy,
    output logic             valid
);
    localparam int CW = $clog2(WIDTH);

    state_e           state, state_n;
    logic [OPW+5:0]   op_w;
    logic [5:0]       opc, op_r;
    logic             accept, iter;
    logic [WIDTH-1:0] add_b, sum, sr;
    logic             add_cin, add_co, add_vo, sc, sv, sz, ss;
    logic [WIDTH-1:0] acc, q, b_r, acc_n, q_n, it_res;
    logic [WIDTH+1:0] it_sum;
    logic             ci_r, vi_r, is_mul, ge, it_v;
    logic [CW-1:0]    cnt;

    // opcodes wider than the defined range map onto an unknown code
    assign op_w   = (OPW + 6)'(op);
    assign opc    = |op_w[OPW+5:6] ? OP_BAD : op_w[5:0];
    assign iter   = is_iterative(opc);
    assign accept = start && state != S_RUN;
    assign busy   = state == S_RUN;

    assign add_b   = opc inside {OP_SUB, OP_SBB, OP_CMP} ? ~bi :
                     opc == OP_INC ? '0 : opc == OP_DEC ? '1 : bi;
    assign add_cin = opc inside {OP_ADC, OP_SBB} ? ci : opc inside {OP_SUB, OP_CMP, OP_INC};

    adder #(.WIDTH(WIDTH)) u_add (
        .a(ai), .b(add_b), .cin(add_cin), .sum(sum), .co(add_co), .vo(add_vo)
    );

    // single-cycle result and flags; cmp/stc/clc keep the current result
    always_comb begin
        sr = di;
        sc = ci;
        sv = vi;
        sz = zi;
        ss = si;
        case (opc)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_INC, OP_DEC, OP_CMP: begin
                sr = opc == OP_CMP ? res : sum;
                sc = add_co;
                sv = add_vo;
                sz = ~|sum;
                ss = sum[WIDTH-1];
            end
            OP_AND: sr = ai & bi;
            OP_OR:  sr = ai | bi;
            OP_XOR: sr = ai ^ bi;
            OP_SHL: begin sr = {ai[WIDTH-2:0], 1'b0};        sc = ai[WIDTH-1]; end
            OP_SHR: begin sr = {1'b0, ai[WIDTH-1:1]};        sc = ai[0];       end
            OP_ROL: begin sr = {ai[WIDTH-2:0], ci};          sc = ai[WIDTH-1]; end
            OP_ROR: begin sr = {ci, ai[WIDTH-1:1]};          sc = ai[0];       end
            OP_SHA: begin sr = {ai[WIDTH-1], ai[WIDTH-1:1]}; sc = ai[0];       end
            OP_STC: begin sr = res; sc = 1'b1; end
            OP_CLC: begin sr = res; sc = 1'b0; end
            default: ;
        endcase
        if (opc inside {OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_SHA})
            sz = ~|sr;
    end

    // one shift/add step: mul adds B into the high half, div trial-subtracts B
    assign is_mul = op_r inside {OP_MUL, OP_MUH};
    assign it_sum = is_mul ? {2'b0, acc} + {2'b0, {WIDTH{q[0]}} & b_r}
                           : {1'b0, acc, q[WIDTH-1]} - {2'b0, b_r};
    assign ge     = !it_sum[WIDTH+1];
    assign acc_n  = is_mul ? it_sum[WIDTH:1] : ge ? it_sum[WIDTH-1:0] : {acc[WIDTH-2:0], q[WIDTH-1]};
    assign q_n    = is_mul ? {it_sum[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ge};
    assign it_res = op_r inside {OP_MUL, OP_DIV} ? q_n : acc_n;
    assign it_v   = op_r == OP_MUL ? |acc_n : op_r == OP_MUH ? vi_r : vi_r | ~|b_r;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    // next state: FIN accepts a new start just like IDLE
    always_comb begin
        state_n = S_IDLE;
        if (accept)
            state_n = iter ? S_RUN : S_IDLE;
        else if (state == S_RUN)
            state_n = cnt == '0 ? S_FIN : S_RUN;
    end

    // result, flags, operand capture and iteration registers
    always_ff @(posedge clk) begin
        if (reset) begin
            res   <= '0;
            {co, vo, zo, so} <= '0;
            valid <= 1'b0;
            acc   <= '0;
            q     <= '0;
            b_r   <= '0;
            op_r  <= '0;
            ci_r  <= 1'b0;
            vi_r  <= 1'b0;
            cnt   <= '0;
        end else begin
            valid <= 1'b0;
            if (accept && iter) begin
                op_r <= opc;
                acc  <= '0;
                q    <= ai;
                b_r  <= bi;
                ci_r <= ci;
                vi_r <= vi;
                cnt  <= CW'(WIDTH - 1);
            end else if (accept) begin
                res   <= sr;
                {co, vo, zo, so} <= {sc, sv, sz, ss};
                valid <= 1'b1;
            end else if (state == S_RUN) begin
                acc <= acc_n;
                q   <= q_n;
                cnt <= cnt - 1'b1;
                if (cnt == '0) begin
                    res   <= it_res;
                    {co, vo, zo, so} <= {ci_r, it_v, ~|it_res, it_res[WIDTH-1]};
                    valid <= 1'b1;
                end
            end
        end
    end
endmodule
